// File: rtl/dice_pkg.sv
// Shared types, default widths and the saturation helper for the dice_pool roll engine.
package dice_pkg;

  localparam int DICE_NUM_BITS   = 8;
  localparam int DICE_RAND_BITS  = 5;
  localparam int DICE_MAX_DICE   = 4;
  localparam int DICE_ENT_DEPTH  = 32;
  localparam int DICE_MAX_REJECT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EVAL,
    ST_FINAL
  } state_e;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_HIGH = 2'b01,
    MODE_LOW  = 2'b10
  } mode_e;

  // Clamp a signed value to the range of an nbits-wide two's complement word.
  function automatic int sat_signed(input int value, input int nbits);
    int hi;
    int lo;
    hi = (1 <<< (nbits - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/dice_entropy_ram.sv
// Entropy store: one write port and one synchronous read port (read-before-write on collision).
module dice_entropy_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dice_pool.sv
// Multi-die roll engine: rejection-samples entropy words into 1..sides, combines, saturates, compares.
// Optional feature macro: DICE_KEEP_EN enables keep-highest / keep-lowest modes.
module dice_pool
  import dice_pkg::*;
#(
  parameter int NUM_BITS   = DICE_NUM_BITS,
  parameter int RAND_BITS  = DICE_RAND_BITS,
  parameter int MAX_DICE   = DICE_MAX_DICE,
  parameter int ENT_DEPTH  = DICE_ENT_DEPTH,
  parameter int MAX_REJECT = DICE_MAX_REJECT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [RAND_BITS-1:0]             sides,
  input  logic [$clog2(MAX_DICE+1)-1:0]    count,
  input  logic [1:0]                       mode,
  input  logic signed [NUM_BITS-1:0]       mod,
  input  logic signed [NUM_BITS-1:0]       target,
  input  logic                             ent_we,
  input  logic [$clog2(ENT_DEPTH)-1:0]     ent_waddr,
  input  logic [RAND_BITS-1:0]             ent_wdata,
  output logic                             busy,
  output logic                             die_valid,
  output logic [RAND_BITS-1:0]             die_val,
  output logic                             done,
  output logic signed [NUM_BITS-1:0]       total,
  output logic                             hit,
  output logic                             fault
);

  localparam int CNT_W = $clog2(MAX_DICE + 1);
  localparam int PTR_W = $clog2(ENT_DEPTH);
  localparam int REJ_W = $clog2(MAX_REJECT + 1);
  localparam int SUM_W = RAND_BITS + CNT_W;

  state_e                      state_q, state_d;
  logic [RAND_BITS-1:0]        sides_q, sides_d;
  logic [CNT_W-1:0]            remain_q, remain_d;
  logic signed [NUM_BITS-1:0]  mod_q, mod_d, target_q, target_d;
  logic [SUM_W-1:0]            sum_q, sum_d;
  logic [REJ_W-1:0]            rej_q, rej_d;
  logic [PTR_W-1:0]            rptr_q, rptr_d;
  logic                        busy_q, busy_d, die_valid_q, die_valid_d;
  logic [RAND_BITS-1:0]        die_val_q, die_val_d;
  logic                        done_q, done_d, hit_q, hit_d, fault_q, fault_d;
  logic signed [NUM_BITS-1:0]  total_q, total_d;
  logic [RAND_BITS-1:0]        ent_rdata;
  logic [SUM_W-1:0]            kept;
  logic                        finish_ok, finish_fault;

`ifdef DICE_KEEP_EN
  mode_e                       mode_q, mode_d;
  logic [RAND_BITS-1:0]        max_q, max_d, min_q, min_d;
`else
  logic                        unused_mode;
  assign unused_mode = ^mode;
`endif

  dice_entropy_ram #(
    .DEPTH (ENT_DEPTH),
    .WIDTH (RAND_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ent_we),
    .waddr (ent_waddr),
    .wdata (ent_wdata),
    .re    (state_q == ST_FETCH),
    .raddr (rptr_q),
    .rdata (ent_rdata)
  );

  always_comb begin
    state_d      = state_q;
    sides_d      = sides_q;
    remain_d     = remain_q;
    mod_d        = mod_q;
    target_d     = target_q;
    sum_d        = sum_q;
    rej_d        = rej_q;
    rptr_d       = rptr_q;
    busy_d       = busy_q;
    die_valid_d  = 1'b0;
    die_val_d    = die_val_q;
    done_d       = 1'b0;
    total_d      = total_q;
    hit_d        = hit_q;
    fault_d      = fault_q;
    finish_ok    = 1'b0;
    finish_fault = 1'b0;
`ifdef DICE_KEEP_EN
    mode_d       = mode_q;
    max_d        = max_q;
    min_d        = min_q;
`endif

    unique case (state_q)
      ST_IDLE: if (start) begin
        sides_d  = sides;
        remain_d = count;
        mod_d    = mod;
        target_d = target;
        sum_d    = '0;
        rej_d    = '0;
        busy_d   = 1'b1;
`ifdef DICE_KEEP_EN
        mode_d   = (mode == 2'b01) ? MODE_HIGH : (mode == 2'b10) ? MODE_LOW : MODE_SUM;
        max_d    = '0;
        min_d    = '1;
`endif
        if (count == '0 || count > CNT_W'(MAX_DICE) || sides == '0) finish_fault = 1'b1;
        else state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rptr_d  = rptr_q + PTR_W'(1);
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (ent_rdata != '0 && ent_rdata <= sides_q) begin
          die_valid_d = 1'b1;
          die_val_d   = ent_rdata;
          sum_d       = sum_q + SUM_W'(ent_rdata);
          remain_d    = remain_q - CNT_W'(1);
`ifdef DICE_KEEP_EN
          if (ent_rdata > max_q) max_d = ent_rdata;
          if (ent_rdata < min_q) min_d = ent_rdata;
`endif
          if (remain_q == CNT_W'(1)) finish_ok = 1'b1;
          else state_d = ST_FETCH;
        end else begin
          rej_d = rej_q + REJ_W'(1);
          if (rej_d == REJ_W'(MAX_REJECT)) finish_fault = 1'b1;
          else state_d = ST_FETCH;
        end
      end
      ST_FINAL: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Results are registered on entry to FINAL so done/total/hit/fault appear together.
    kept = sum_d;
`ifdef DICE_KEEP_EN
    case (mode_q)
      MODE_HIGH: kept = SUM_W'(max_d);
      MODE_LOW:  kept = SUM_W'(min_d);
      default:   kept = sum_d;
    endcase
`endif
    if (finish_ok) begin
      state_d = ST_FINAL;
      done_d  = 1'b1;
      total_d = NUM_BITS'(sat_signed(int'(kept) + int'(mod_q), NUM_BITS));
      hit_d   = (total_d >= target_q);
      fault_d = 1'b0;
    end
    if (finish_fault) begin
      state_d = ST_FINAL;
      done_d  = 1'b1;
      total_d = '0;
      hit_d   = 1'b0;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sides_q     <= '0;
      remain_q    <= '0;
      mod_q       <= '0;
      target_q    <= '0;
      sum_q       <= '0;
      rej_q       <= '0;
      rptr_q      <= '0;
      busy_q      <= 1'b0;
      die_valid_q <= 1'b0;
      die_val_q   <= '0;
      done_q      <= 1'b0;
      total_q     <= '0;
      hit_q       <= 1'b0;
      fault_q     <= 1'b0;
`ifdef DICE_KEEP_EN
      mode_q      <= MODE_SUM;
      max_q       <= '0;
      min_q       <= '1;
`endif
    end else begin
      state_q     <= state_d;
      sides_q     <= sides_d;
      remain_q    <= remain_d;
      mod_q       <= mod_d;
      target_q    <= target_d;
      sum_q       <= sum_d;
      rej_q       <= rej_d;
      rptr_q      <= rptr_d;
      busy_q      <= busy_d;
      die_valid_q <= die_valid_d;
      die_val_q   <= die_val_d;
      done_q      <= done_d;
      total_q     <= total_d;
      hit_q       <= hit_d;
      fault_q     <= fault_d;
`ifdef DICE_KEEP_EN
      mode_q      <= mode_d;
      max_q       <= max_d;
      min_q       <= min_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign die_valid = die_valid_q;
  assign die_val   = die_val_q;
  assign done      = done_q;
  assign total     = total_q;
  assign hit       = hit_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_dice_pool.sv
// Scoreboard bench for dice_pool: reference model pushes expected dice/results, a monitor pops and compares.
module tb_dice_pool;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4:0]        sides = '0;
  logic [2:0]        count = '0;
  logic [1:0]        mode = '0;
  logic signed [7:0] mod = '0;
  logic signed [7:0] target = '0;
  logic              ent_we = 1'b0;
  logic [4:0]        ent_waddr = '0;
  logic [4:0]        ent_wdata = '0;
  logic              busy, die_valid, done, hit, fault;
  logic [4:0]        die_val;
  logic signed [7:0] total;

  dice_pool #(
    .NUM_BITS   (8),
    .RAND_BITS  (5),
    .MAX_DICE   (4),
    .ENT_DEPTH  (32),
    .MAX_REJECT (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sides     (sides),
    .count     (count),
    .mode      (mode),
    .mod       (mod),
    .target    (target),
    .ent_we    (ent_we),
    .ent_waddr (ent_waddr),
    .ent_wdata (ent_wdata),
    .busy      (busy),
    .die_valid (die_valid),
    .die_val   (die_val),
    .done      (done),
    .total     (total),
    .hit       (hit),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int total;
    int hit;
    int fault;
    int cyc;
  } res_t;

  res_t res_q[$];
  int   die_q[$];
  int   ram_m[32];
  int   rptr_m = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every die_valid / done.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (die_valid) begin
        if (die_q.size() == 0) chk("unexpected_die", 1, 0);
        else chk("die_val", int'(die_val), die_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (res_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("total", int'(total), r.total);
          chk("hit", int'(hit), r.hit);
          chk("fault", int'(fault), r.fault);
          chk("done_cycle", cyc, r.cyc);
          chk("busy_at_done", int'(busy), 1);
          chk("dice_drained", die_q.size(), 0);
        end
      end
    end
  end

  task automatic ram_write(input int a, input int d);
    ent_we    = 1'b1;
    ent_waddr = 5'(a);
    ent_wdata = 5'(d);
    @(posedge clk); #1;
    ent_we    = 1'b0;
    ram_m[a]  = d;
  endtask

  task automatic fill_ram(input int d);
    for (int i = 0; i < 32; i++) ram_write(i, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rptr_m = 0;
    res_q.delete();
    die_q.delete();
  endtask

  // Reference roll: walk the entropy array, accept 1..s, give up after 64 rejects.
  task automatic do_roll(input int s, input int c, input int m, input int md, input int tg);
    res_t r;
    int n, rj, v, sum, mx, mn, kept, tgt;
    bit flt;
    n = 0; rj = 0; sum = 0; mx = 0; mn = 32; flt = 0;
    if (c == 0 || c > 4 || s == 0) begin
      flt = 1;
      r.cyc = cyc + 1;
    end else begin
      while (n < c && !flt) begin
        v = ram_m[rptr_m];
        rptr_m = (rptr_m + 1) % 32;
        if (v >= 1 && v <= s) begin
          die_q.push_back(v);
          n++;
          sum += v;
          if (v > mx) mx = v;
          if (v < mn) mn = v;
        end else begin
          rj++;
          if (rj == 64) flt = 1;
        end
      end
      r.cyc = cyc + 2 * (n + rj) + 1;
    end
`ifdef DICE_KEEP_EN
    kept = (m == 1) ? mx : (m == 2) ? mn : sum;
`else
    kept = sum;
`endif
    r.total = kept + md;
    if (r.total > 127) r.total = 127;
    if (r.total < -128) r.total = -128;
    r.hit = (r.total >= tg) ? 1 : 0;
    r.fault = 0;
    if (flt) begin
      r.total = 0; r.hit = 0; r.fault = 1;
    end
    res_q.push_back(r);
    sides  = 5'(s);
    count  = 3'(c);
    mode   = 2'(m);
    mod    = 8'(md);
    target = 8'(tg);
    start  = 1'b1;
    tgt    = done_cnt + 1;
    @(posedge clk); #1;
    start  = 1'b0;
    for (int i = 0; i < 400 && done_cnt < tgt; i++) @(posedge clk);
    #1;
    if (done_cnt < tgt) chk("done_timeout", 0, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("rptr", int'(dut.rptr_q), rptr_m);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_total", int'(total), 0);
    chk("reset_fault", int'(fault), 0);
    reset = 1'b0;
    fill_ram(0);

    ram_write(0, 5); ram_write(1, 12); ram_write(2, 20); ram_write(3, 3);
    do_roll(20, 3, 0, 2, 40);

    do_reset();
    ram_write(0, 0); ram_write(1, 25); ram_write(2, 21); ram_write(3, 7);
    do_roll(20, 1, 0, 5, 10);

    do_reset();
    fill_ram(0);
    do_roll(20, 1, 0, 3, -5);

    do_reset();
    ram_write(0, 4); ram_write(1, 17);
    do_roll(20, 2, 1, -3, 14);
    do_reset();
    do_roll(20, 2, 2, -3, 14);

    fill_ram(31);
    do_roll(31, 4, 0, 127, 127);
    do_roll(20, 0, 0, 1, 0);
    do_roll(20, 5, 0, 1, 0);
    do_roll(0, 2, 0, 1, 0);

    // Reset during cycle 3 of a valid roll: one die escapes, no done follows.
    sides = 5'd31; count = 3'd4; mode = 2'd0; mod = 8'sd1; target = 8'sd0;
    die_q.push_back(31);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_total", int'(total), 0);
    chk("midreset_hit", int'(hit), 0);
    chk("midreset_fault", int'(fault), 0);
    chk("midreset_rptr", int'(dut.rptr_q), 0);
    chk("midreset_die_drained", die_q.size(), 0);
    rptr_m = 0;
    res_q.delete();
    die_q.delete();
    repeat (10) @(posedge clk);
    #1;

    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < 32; a++) ram_write(a, int'($urandom_range(0, 31)));
      do_roll(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end

    chk("scoreboard_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
